psum_adder_pipe: RTL and testbench

Pipelined, parametrised partial-sum adder for the CNN convolution datapath. Sums `NUM_IN` PE products with an optional partial sum and bias, and can carry a running accumulator across back-to-back beats. Produces both the full-width sum and a rounded, saturated, optionally ReLU'd `DATA_BITS` activation. Sits between the PE array and the output/psum buffers and supports valid/ready backpressure.

---
 rtl/psum_adder_pipe.sv | 161 ++++++++++++++++
 tb/tb_psum_adder_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_adder_pipe.sv
// Three-stage partial-sum adder: product reduction, psum/bias/accumulator select,
// then round, saturate and optional ReLU, with valid/ready flow control.
module psum_adder_pipe #(
    parameter int NUM_IN        = 3,
    parameter int INTERNAL_BITS = 32,
    parameter int DATA_BITS     = 16,
    parameter int SHIFT         = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_IN*INTERNAL_BITS-1:0] data_in,
    input  logic [INTERNAL_BITS-1:0]        psum,
    input  logic [DATA_BITS-1:0]            bias,
    input  logic [1:0]                      mode,
    input  logic                            relu_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [INTERNAL_BITS-1:0]        result,
    output logic [DATA_BITS-1:0]            result_q,
    output logic                            sat
);

    localparam int W  = INTERNAL_BITS;
    localparam int EW = INTERNAL_BITS + 1;

    // Half-LSB rounding constant; collapses to zero when SHIFT is zero.
    localparam logic signed [EW-1:0] RND_C  = ({{(EW-1){1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic signed [EW-1:0] QMAX_C = {{(EW-DATA_BITS+1){1'b0}}, {(DATA_BITS-1){1'b1}}};
    localparam logic signed [EW-1:0] QMIN_C = {{(EW-DATA_BITS+1){1'b1}}, {(DATA_BITS-1){1'b0}}};

    // Returns {sat, q}: sat reflects clamping before ReLU is applied.
    function automatic logic [DATA_BITS:0] quantise(input logic [W-1:0] val, input logic relu);
        logic signed [EW-1:0] rnd_s;
        logic signed [EW-1:0] shf_s;
        logic [DATA_BITS-1:0] q_s;
        logic                 sat_s;
        rnd_s = $signed({val[W-1], val}) + RND_C;
        shf_s = rnd_s >>> SHIFT;
        if (shf_s > QMAX_C) begin
            q_s   = QMAX_C[DATA_BITS-1:0];
            sat_s = 1'b1;
        end else if (shf_s < QMIN_C) begin
            q_s   = QMIN_C[DATA_BITS-1:0];
            sat_s = 1'b1;
        end else begin
            q_s   = shf_s[DATA_BITS-1:0];
            sat_s = 1'b0;
        end
        q_s = (relu && q_s[DATA_BITS-1]) ? {DATA_BITS{1'b0}} : q_s;
        return {sat_s, q_s};
    endfunction

    logic                 s1_valid_r;
    logic [W-1:0]         s1_sum_r;
    logic [W-1:0]         s1_psum_r;
    logic [W-1:0]         s1_bias_r;
    logic [1:0]           s1_mode_r;
    logic                 s1_relu_r;
    logic                 s2_valid_r;
    logic [W-1:0]         s2_res_r;
    logic                 s2_relu_r;
    logic [W-1:0]         acc_r;
    logic                 s3_valid_r;

    logic                 s1_en_s;
    logic                 s2_en_s;
    logic                 s3_en_s;
    logic [W-1:0]         tree_sum_s;
    logic [W-1:0]         s2_next_s;
    logic [DATA_BITS:0]   quant_s;

    // A stage may load when it is empty or its content is moving on this edge.
    assign s3_en_s   = ~s3_valid_r | out_ready;
    assign s2_en_s   = ~s2_valid_r | s3_en_s;
    assign s1_en_s   = ~s1_valid_r | s2_en_s;
    assign in_ready  = s1_en_s;
    assign out_valid = s3_valid_r;

    // Reduction of the product inputs; wraps modulo 2^W.
    always_comb begin
        tree_sum_s = {W{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            tree_sum_s = tree_sum_s + data_in[i*W +: W];
        end
    end

    // Mode select for the second stage.
    always_comb begin
        s2_next_s = s1_sum_r;
        case (s1_mode_r)
            2'b00:   s2_next_s = s1_sum_r;
            2'b01:   s2_next_s = s1_sum_r + s1_psum_r;
            2'b10:   s2_next_s = s1_sum_r + s1_psum_r + s1_bias_r;
            2'b11:   s2_next_s = s1_sum_r + acc_r;
            default: s2_next_s = s1_sum_r;
        endcase
    end

    // Quantisation of the stage-two result feeding the output register.
    always_comb begin
        quant_s = quantise(s2_res_r, s2_relu_r);
    end

    // Stage one: capture the reduced sum and side operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sum_r   <= {W{1'b0}};
            s1_psum_r  <= {W{1'b0}};
            s1_bias_r  <= {W{1'b0}};
            s1_mode_r  <= 2'b00;
            s1_relu_r  <= 1'b0;
        end else if (s1_en_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sum_r  <= tree_sum_s;
                s1_psum_r <= psum;
                s1_bias_r <= W'($signed(bias));
                s1_mode_r <= mode;
                s1_relu_r <= relu_en;
            end
        end
    end

    // Stage two: the accumulator follows every real load so mode 11 chains in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_res_r   <= {W{1'b0}};
            s2_relu_r  <= 1'b0;
            acc_r      <= {W{1'b0}};
        end else if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_res_r  <= s2_next_s;
                s2_relu_r <= s1_relu_r;
                acc_r     <= s2_next_s;
            end
        end
    end

    // Stage three: registered outputs, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_r <= 1'b0;
            result     <= {W{1'b0}};
            result_q   <= {DATA_BITS{1'b0}};
            sat        <= 1'b0;
        end else if (s3_en_s) begin
            s3_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                result   <= s2_res_r;
                result_q <= quant_s[DATA_BITS-1:0];
                sat      <= quant_s[DATA_BITS];
            end
        end
    end

endmodule

// File: tb/tb_psum_adder_pipe.sv
// Table-driven scoreboard bench: two instances (16-bit/no shift and 8-bit/shift 4)
// share all stimulus, so every beat checks both quantisers.
module tb_psum_adder_pipe;

    localparam int NI = 3;
    localparam int W  = 32;

    typedef struct {
        logic [31:0] res;
        logic [15:0] q16;
        logic        s16;
        logic [7:0]  q8;
        logic        s8;
    } exp_t;

    typedef struct {
        int         d0, d1, d2, p, b;
        logic [1:0] m;
        logic       rl;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            in_valid;
    logic [NI*W-1:0] data_in;
    logic [W-1:0]    psum;
    logic [15:0]     bias;
    logic [1:0]      mode;
    logic            relu_en;
    logic            ready_force;
    logic            toggle_en;
    logic            tog_r = 1'b0;
    logic            out_ready;
    logic            in_ready, out_valid, sat;
    logic [W-1:0]    result;
    logic [15:0]     result_q;
    logic            in_ready_b, out_valid_b, sat_b;
    logic [W-1:0]    result_b;
    logic [7:0]      result_qb;

    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    exp_t exp_q[$];
    vec_t tbl[21];
    logic        hold_pend = 1'b0;
    logic [31:0] held_res;
    logic [15:0] held_q;

    assign out_ready = toggle_en ? tog_r : ready_force;

    // Produces a 1010... out_ready pattern when enabled.
    always begin
        @(posedge clk);
        #1;
        tog_r = ~tog_r;
    end

    psum_adder_pipe #(.NUM_IN(NI), .INTERNAL_BITS(W), .DATA_BITS(16), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .psum(psum), .bias(bias), .mode(mode), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_q(result_q), .sat(sat)
    );

    psum_adder_pipe #(.NUM_IN(NI), .INTERNAL_BITS(W), .DATA_BITS(8), .SHIFT(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .data_in(data_in), .psum(psum), .bias(bias[7:0]), .mode(mode), .relu_en(relu_en),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .result(result_b), .result_q(result_qb), .sat(sat_b)
    );

    function automatic vec_t mk(int d0, int d1, int d2, int p, int b, int m, int rl,
                                int res, int q16, int s16, int q8, int s8);
        vec_t v;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.p = p; v.b = b;
        v.m = m[1:0]; v.rl = rl[0];
        v.e.res = res; v.e.q16 = q16[15:0]; v.e.s16 = s16[0];
        v.e.q8 = q8[7:0]; v.e.s8 = s8[0];
        return v;
    endfunction

    task automatic chk(input string name, input integer act, input integer req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic mon_step();
        exp_t e;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && out_valid) begin
                chk("hold_result", result, held_res);
                chk("hold_result_q", $signed(result_q), $signed(held_q));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output_queue_size", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("result_q16", $signed(result_q), $signed(e.q16));
                    chk("sat16", sat, e.s16);
                    chk("valid_b", out_valid_b, 1);
                    chk("result_b", result_b, e.res);
                    chk("result_q8", $signed(result_qb), $signed(e.q8));
                    chk("sat8", sat_b, e.s8);
                end
            end
            hold_pend = out_valid && !out_ready;
            held_res  = result;
            held_q    = result_q;
        end
    endtask

    task automatic send(input vec_t v);
        int t;
        t = 0;
        in_valid = 1'b1;
        data_in  = {v.d2, v.d1, v.d0};
        psum     = v.p;
        bias     = v.b[15:0];
        mode     = v.m;
        relu_en  = v.rl;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (in_ready) begin
            exp_q.push_back(v.e);
            acc_cnt++;
        end else begin
            chk("accept_timeout", in_ready, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_q"}, result_q, 0);
        chk({tag, "_sat"}, sat, 0);
        chk({tag, "_out_valid_b"}, out_valid_b, 0);
        chk({tag, "_result_qb"}, result_qb, 0);
    endtask

    initial begin
        //           d0          d1    d2  psum bias m rl  result        q16     s q8   s
        tbl[0]  = mk(5,          -2,   10, 0,   0,   0, 0, 13,           13,     0, 1,    0);
        tbl[1]  = mk(1,          2,    3,  100, -7,  1, 0, 106,          106,    0, 7,    0);
        tbl[2]  = mk(1,          2,    3,  100, -7,  2, 0, 99,           99,     0, 6,    0);
        tbl[3]  = mk(32'h7FFFFFFF, 1,  0,  0,   0,   0, 0, 32'h80000000, -32768, 1, -128, 1);
        tbl[4]  = mk(40,         0,    0,  77,  3,   0, 0, 40,           40,     0, 3,    0);
        tbl[5]  = mk(5000,       0,    0,  0,   0,   0, 0, 5000,         5000,   0, 127,  1);
        tbl[6]  = mk(-5000,      0,    0,  0,   0,   0, 0, -5000,        -5000,  0, -128, 1);
        tbl[7]  = mk(-5000,      0,    0,  0,   0,   0, 1, -5000,        0,      0, 0,    1);
        tbl[8]  = mk(2039,       0,    0,  0,   0,   0, 0, 2039,         2039,   0, 127,  0);
        tbl[9]  = mk(2040,       0,    0,  0,   0,   0, 0, 2040,         2040,   0, 127,  1);
        tbl[10] = mk(-2056,      0,    0,  0,   0,   0, 0, -2056,        -2056,  0, -128, 0);
        tbl[11] = mk(-2057,      0,    0,  0,   0,   0, 0, -2057,        -2057,  0, -128, 1);
        tbl[12] = mk(30000,      2768, 0,  0,   0,   0, 0, 32768,        32767,  1, 127,  1);
        tbl[13] = mk(-32769,     0,    0,  0,   0,   0, 1, -32769,       0,      1, 0,    1);
        tbl[14] = mk(-3,         0,    0,  0,   0,   0, 1, -3,           0,      0, 0,    0);
        tbl[15] = mk(0,          0,    0,  0,   -100, 2, 0, -100,        -100,   0, -6,   0);
        tbl[16] = mk(1,          1,    1,  0,   4,   2, 0, 7,            7,      0, 0,    0);
        tbl[17] = mk(2,          0,    0,  50,  9,   3, 0, 9,            9,      0, 1,    0);
        tbl[18] = mk(2,          0,    0,  50,  9,   3, 0, 11,           11,     0, 1,    0);
        tbl[19] = mk(2,          0,    0,  50,  9,   3, 0, 13,           13,     0, 1,    0);
        tbl[20] = mk(4,          0,    0,  0,   0,   3, 0, 4,            4,      0, 0,    0);

        rst = 1'b1; in_valid = 1'b0; data_in = '0; psum = '0; bias = '0;
        mode = 2'b00; relu_en = 1'b0; ready_force = 1'b1; toggle_en = 1'b0;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);
        chk("out_valid_after_reset", out_valid, 0);
        chk_zero("post_reset");

        // Latency: the accepting edge is the first of three edges before out_valid.
        @(posedge clk);
        #1;
        send(tbl[0]);
        in_valid = 1'b0;
        @(negedge clk); chk("latency_edge1", out_valid, 0);
        @(negedge clk); chk("latency_edge2", out_valid, 0);
        @(negedge clk); chk("latency_edge3", out_valid, 1);
        drain();

        for (int i = 1; i <= 15; i++) send(tbl[i]);
        in_valid = 1'b0;
        drain();

        // Accumulate chain, free-running then with a toggling out_ready.
        for (int rep = 0; rep < 2; rep++) begin
            toggle_en = rep[0];
            for (int i = 16; i <= 19; i++) send(tbl[i]);
            in_valid = 1'b0;
            drain();
            toggle_en = 1'b0;
        end

        // Backpressure: 10 beats into a stalled pipe, released after 6 cycles.
        ready_force = 1'b0;
        acc_cnt = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(mk(16*i, 8, 0, 0, 0, 0, 0, 16*i+8, 16*i+8, 0, i+1, 0));
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                chk("accepts_before_full", acc_cnt, 3);
                chk("in_ready_when_full", in_ready, 0);
                @(posedge clk);
                #1;
                ready_force = 1'b1;
            end
        join
        drain();
        chk("backpressure_accepts", acc_cnt, 10);

        // Reset with three beats in flight discards them and clears the accumulator.
        ready_force = 1'b0;
        send(tbl[1]);
        send(tbl[2]);
        send(tbl[4]);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        @(negedge clk);
        chk_zero("mid_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_mid_reset", in_ready, 1);
        repeat (5) @(negedge clk);
        chk("no_output_after_mid_reset", out_valid, 0);
        @(posedge clk);
        #1;
        send(tbl[20]);
        in_valid = 1'b0;
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
